// File: rtl/fifo_rd_arb_pkg.sv
// Shared types and parameter helpers for the FIFO read-port arbiter.
package fifo_rd_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned NREQ_MIN  = 2;
  localparam int unsigned NREQ_MAX  = 16;
  localparam int unsigned BURST_MIN = 1;
  localparam int unsigned BURST_MAX = 16;

  // Burst counter must hold values 0..BURST.
  function automatic int unsigned CNTW(input int unsigned burst);
    return $clog2(burst + 1);
  endfunction

  function automatic bit params_ok(input int unsigned nreq, input int unsigned burst);
    return (nreq >= NREQ_MIN) && (nreq <= NREQ_MAX) &&
           (burst >= BURST_MIN) && (burst <= BURST_MAX);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from
// last+1, wrapping modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic            valid,
  output logic [LW-1:0]   idx
);

  logic [LW-1:0] w_j;

  // Scan from the farthest candidate down so the nearest hit is assigned last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    w_j   = '0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      w_j = LW'((int'(last) + k) % int'(NREQ));
      if (req[w_j]) begin
        valid = 1'b1;
        idx   = w_j;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Shares a sync FIFO read port among NREQ consumers with round-robin, bounded bursts.
// Define FIFO_RD_ARB_PRIO0_EN to let consumer 0 win every arbitration it requests.
module fifo_rd_arbiter
  import fifo_rd_arb_pkg::*;
#(
  parameter int unsigned ADDRSIZE = 4,
  parameter int unsigned DSIZE    = 8,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned BURST    = 4
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  rdy,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  dvalid,
  output logic [DSIZE-1:0] dout
);

  localparam int unsigned LW = $clog2(NREQ);
  localparam int unsigned CW = CNTW(BURST);

  if (!params_ok(NREQ, BURST) || (ADDRSIZE == 0)) begin : g_param_err
    $error("fifo_rd_arbiter: NREQ, BURST or ADDRSIZE out of range");
  end

  arb_state_e      r_state, w_state_d;
  logic [NREQ-1:0] r_gnt, w_gnt_d;
  logic [LW-1:0]   r_cur, w_cur_d;
  logic [LW-1:0]   r_last, w_last_d;
  logic [CW-1:0]   r_cnt, w_cnt_d;

  logic            w_pick_valid;
  logic [LW-1:0]   w_pick_idx;
  logic [LW-1:0]   w_win_idx;
  logic [NREQ-1:0] w_win_oh;
  logic [NREQ-1:0] w_cur_oh;
  logic            w_dv;
  logic            w_xfer;
  logic            w_last_word;

  rr_pick #(
    .NREQ (NREQ),
    .LW   (LW)
  ) u_rr_pick (
    .req   (req),
    .last  (r_last),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

`ifdef FIFO_RD_ARB_PRIO0_EN
  assign w_win_idx = req[0] ? '0 : w_pick_idx;
`else
  assign w_win_idx = w_pick_idx;
`endif

  always_comb begin
    w_win_oh            = '0;
    w_win_oh[w_win_idx] = 1'b1;
    w_cur_oh            = '0;
    w_cur_oh[r_cur]     = 1'b1;
  end

  // rempty gates the pop directly, so a word is never read past the last one.
  assign w_dv        = (r_state == ARB_GRANT) && !rempty && req[r_cur] && !rrst;
  assign w_xfer      = w_dv && rdy[r_cur];
  assign w_last_word = (r_cnt == CW'(BURST - 1));

  assign rinc   = w_xfer;
  assign dvalid = w_dv ? w_cur_oh : '0;
  assign gnt    = r_gnt;
  assign dout   = rdata;

  always_comb begin
    w_state_d = r_state;
    w_gnt_d   = r_gnt;
    w_cur_d   = r_cur;
    w_last_d  = r_last;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      ARB_IDLE: begin
        if (!rempty && w_pick_valid) begin
          w_state_d = ARB_GRANT;
          w_gnt_d   = w_win_oh;
          w_cur_d   = w_win_idx;
          w_cnt_d   = '0;
        end
      end
      ARB_GRANT: begin
        if (w_xfer) begin
          w_cnt_d = r_cnt + 1'b1;
        end
        // A pop in the exit cycle still completes; only the grant is released.
        if ((w_xfer && w_last_word) || !req[r_cur] || rempty) begin
          w_state_d = ARB_IDLE;
          w_gnt_d   = '0;
          w_last_d  = r_cur;
          w_cnt_d   = '0;
        end
      end
      default: w_state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_state <= ARB_IDLE;
      r_gnt   <= '0;
      r_cur   <= '0;
      r_last  <= LW'(NREQ - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_gnt   <= w_gnt_d;
      r_cur   <= w_cur_d;
      r_last  <= w_last_d;
      r_cnt   <= w_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Self-checking bench for fifo_rd_arbiter: FIFO model plus a pop scoreboard of
// (consumer, word) pairs checked whenever the DUT pops.
module tb_fifo_rd_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned DSIZE = 8;
  localparam int unsigned BURST = 4;

`ifdef FIFO_RD_ARB_PRIO0_EN
  localparam int PRIO_EXP = 0;
  localparam int T4_EXP   = 0;
`else
  localparam int PRIO_EXP = 1;
  localparam int T4_EXP   = 3;
`endif

  logic             rclk = 1'b0;
  logic             rrst;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  rdy;
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  dvalid;
  logic [DSIZE-1:0] dout;

  always #5 rclk = ~rclk;

  fifo_rd_arbiter #(
    .ADDRSIZE (4),
    .DSIZE    (DSIZE),
    .NREQ     (NREQ),
    .BURST    (BURST)
  ) dut (
    .rclk   (rclk),
    .rrst   (rrst),
    .req    (req),
    .rdy    (rdy),
    .rempty (rempty),
    .rdata  (rdata),
    .rinc   (rinc),
    .gnt    (gnt),
    .dvalid (dvalid),
    .dout   (dout)
  );

  typedef struct packed {
    logic [3:0]       cons;
    logic [DSIZE-1:0] data;
  } sb_t;

  sb_t              sb[$];
  logic [DSIZE-1:0] fifo_q[$];
  logic [DSIZE-1:0] data_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fifo_refresh();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? '0 : fifo_q[0];
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      logic [DSIZE-1:0] d;
      d = DSIZE'($urandom);
      fifo_q.push_back(d);
      data_q.push_back(d);
    end
    fifo_refresh();
  endtask

  task automatic expect_pops(input int cons, input int n);
    for (int i = 0; i < n; i++) begin
      sb_t e;
      e.cons = 4'(cons);
      e.data = data_q.pop_front();
      sb.push_back(e);
    end
  endtask

  // One clock: check pops at the falling edge, then advance the FIFO model.
  task automatic tick();
    logic pop;
    sb_t  e;
    pop = 1'b0;
    @(negedge rclk);
    check("dout_eq_rdata", 32'(dout), 32'(rdata));
    if (rinc) begin
      pop = 1'b1;
      check("rinc_when_nonempty", 32'(rempty), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pop", 32'(rinc), 32'd0);
      end else begin
        e = sb.pop_front();
        check("pop_dvalid", 32'(dvalid), 32'd1 << e.cons);
        check("pop_data", 32'(dout), 32'(e.data));
      end
    end
    @(posedge rclk);
    #1;
    if (pop) void'(fifo_q.pop_front());
    fifo_refresh();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset holds everything off even with data and requests present.
    rrst = 1'b1;
    req  = '0;
    rdy  = '0;
    fifo_refresh();
    load(2);
    req = 4'b1111;
    rdy = 4'b1111;
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rinc", 32'(rinc), 32'd0);
    check("rst_dvalid", 32'(dvalid), 32'd0);
    fifo_q.delete();
    data_q.delete();
    fifo_refresh();
    req  = '0;
    rrst = 1'b0;
    #1;

    // Three words to consumer 0, exit on empty.
    load(3);
    expect_pops(0, 3);
    req = 4'b0001;
    #1;
    check("t1_idle_gnt", 32'(gnt), 32'd0);
    check("t1_idle_rinc", 32'(rinc), 32'd0);
    tick();
    check("t1_gnt", 32'(gnt), 32'b0001);
    check("t1_rinc0", 32'(rinc), 32'd1);
    tick();
    check("t1_rinc1", 32'(rinc), 32'd1);
    tick();
    check("t1_rinc2", 32'(rinc), 32'd1);
    tick();
    check("t1_empty_rinc", 32'(rinc), 32'd0);
    check("t1_hold_gnt", 32'(gnt), 32'b0001);
    tick();
    check("t1_exit_gnt", 32'(gnt), 32'd0);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);
    req = '0;

    // last=0, req=0011: round-robin picks 1, priority mode picks 0.
    load(2);
    expect_pops(PRIO_EXP, 2);
    req = 4'b0011;
    #1;
    tick();
    check("prio_gnt", 32'(gnt), 32'd1 << PRIO_EXP);
    for (int i = 0; i < 4; i++) tick();
    req = '0;
    check("prio_exit_gnt", 32'(gnt), 32'd0);
    check("prio_sb_empty", 32'(sb.size()), 32'd0);

    // Full round-robin rotation with wrap back to 0 and one idle bubble per grant.
    rrst = 1'b1;
    tick();
    rrst = 1'b0;
    check("t2_rst_gnt", 32'(gnt), 32'd0);
    load(20);
    for (int g = 0; g < 5; g++) expect_pops(g % 4, 4);
    req = 4'b1111;
    rdy = 4'b1111;
    #1;
    for (int k = 0; k < 25; k++) begin
      tick();
      check($sformatf("t2_gnt_%0d", k), 32'(gnt),
            (k % 5 == 4) ? 32'd0 : (32'd1 << ((k / 5) % 4)));
      check($sformatf("t2_rinc_%0d", k), 32'(rinc), (k % 5 == 4) ? 32'd0 : 32'd1);
    end
    check("t2_sb_empty", 32'(sb.size()), 32'd0);
    req = '0;

    // Consumer 2 stalls for three cycles; the burst count must hold.
    load(5);
    expect_pops(2, 4);
    req = 4'b0100;
    rdy = 4'b1011;
    #1;
    tick();
    check("t3_gnt", 32'(gnt), 32'b0100);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("t3_stall_dvalid_%0d", s), 32'(dvalid), 32'b0100);
      check($sformatf("t3_stall_rinc_%0d", s), 32'(rinc), 32'd0);
      if (s < 2) tick();
    end
    rdy = 4'b1111;
    #1;
    for (int p = 0; p < 4; p++) begin
      check($sformatf("t3_resume_rinc_%0d", p), 32'(rinc), 32'd1);
      tick();
    end
    check("t3_burst_exit_gnt", 32'(gnt), 32'd0);
    req = '0;

    // Consumer 1 drops its request after two pops.
    load(5);
    expect_pops(1, 2);
    expect_pops(T4_EXP, 4);
    req = 4'b0010;
    #1;
    tick();
    check("t4_gnt", 32'(gnt), 32'b0010);
    tick();
    tick();
    req = 4'b1001;
    #1;
    check("t4_drop_rinc", 32'(rinc), 32'd0);
    tick();
    check("t4_exit_gnt", 32'(gnt), 32'd0);
    tick();
    check("t4_next_gnt", 32'(gnt), 32'd1 << T4_EXP);
    for (int i = 0; i < 4; i++) tick();
    check("t4_done_gnt", 32'(gnt), 32'd0);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);
    req = '0;

    // Reset in the middle of a burst: no pop in the reset cycle.
    load(8);
    expect_pops(1, 1);
    expect_pops(1, 4);
    expect_pops(2, 3);
    req = 4'b0110;
    #1;
    tick();
    check("t5_gnt", 32'(gnt), 32'b0010);
    check("t5_pre_rinc", 32'(rinc), 32'd1);
    tick();
    rrst = 1'b1;
    #1;
    check("t5_rst_rinc", 32'(rinc), 32'd0);
    check("t5_rst_dvalid", 32'(dvalid), 32'd0);
    tick();
    rrst = 1'b0;
    #1;
    check("t5_after_rst_gnt", 32'(gnt), 32'd0);
    tick();
    check("t5_regrant", 32'(gnt), 32'b0010);
    for (int i = 0; i < 11; i++) tick();
    check("t5_done_gnt", 32'(gnt), 32'd0);
    check("t5_sb_empty", 32'(sb.size()), 32'd0);
    req = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
